// File: rtl/hc138_sched_pkg.sv
// rtl/hc138_sched_pkg.sv - shared states and constants for the hc138 chip-select scheduler
package hc138_sched_pkg;

    localparam int         N_REQ   = 8;
    localparam int         IDX_W   = 3;
    localparam logic [2:0] DEC_ON  = 3'b111;
    localparam logic [2:0] DEC_OFF = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACTIVE,
        RECOVER
    } sched_state_e;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        idx_to_onehot = N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/hc138_cs_scheduler_if.sv
// rtl/hc138_cs_scheduler_if.sv - requester and decoder-side signals of the chip-select scheduler
interface hc138_cs_scheduler_if;
    import hc138_sched_pkg::*;

    logic [N_REQ-1:0] req;
    logic [IDX_W-1:0] dec_addr;
    logic [2:0]       dec_en;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             timeout;

    modport master (
        output req,
        input  dec_addr, dec_en, grant, busy, timeout
    );

    modport slave (
        input  req,
        output dec_addr, dec_en, grant, busy, timeout
    );

endinterface

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin pick of 8 requesters, searching from last_ptr+1
module rr_pick8
    import hc138_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        idx_o = '0;
        cand  = '0;
        // Walk from the farthest candidate back toward last_ptr+1 so the nearest set bit wins.
        for (int i = N_REQ; i >= 1; i--) begin
            cand = last_ptr_i + IDX_W'(i);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/hc138_cs_scheduler.sv
// rtl/hc138_cs_scheduler.sv - round-robin scheduler sequencing hc138 address/enable with setup and recovery
// Optional per-grant hold limit with timeout pulse: define HC138_SCHED_TIMEOUT_EN.
module hc138_cs_scheduler
    import hc138_sched_pkg::*;
#(
    parameter int SETUP_CYC   = 1,
    parameter int RECOVER_CYC = 1,
    parameter int MAX_HOLD    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hc138_cs_scheduler_if.slave  bus
);

    // Illegal parameter values hold the scheduler idle rather than mistime the decoder.
    localparam bit CFG_OK = (SETUP_CYC >= 1) && (SETUP_CYC <= 15) &&
                            (RECOVER_CYC >= 1) && (RECOVER_CYC <= 15) &&
                            (MAX_HOLD >= 2) && (MAX_HOLD <= 255);
    localparam logic [3:0] SETUP_LAST   = 4'(SETUP_CYC - 1);
    localparam logic [3:0] RECOVER_LAST = 4'(RECOVER_CYC - 1);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
    logic [2:0]       en_q, en_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [3:0]       phase_q, phase_d, phase_inc;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             release_now;

`ifdef HC138_SCHED_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    logic [7:0] hold_q, hold_d, hold_inc;
    logic       timeout_q, timeout_d;

    assign hold_inc = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
`endif

    rr_pick8 u_pick (
        .req_i      (bus.req),
        .last_ptr_i (last_ptr_q),
        .idx_o      (pick_idx),
        .any_o      (pick_any)
    );

    assign phase_inc = (phase_q == 4'hF) ? phase_q : phase_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_ptr_d  = last_ptr_q;
        en_d        = en_q;
        grant_d     = grant_q;
        phase_d     = phase_q;
        release_now = 1'b0;
`ifdef HC138_SCHED_TIMEOUT_EN
        hold_d      = hold_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (CFG_OK && pick_any) begin
                    addr_d  = pick_idx;
                    phase_d = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!bus.req[addr_q]) begin
                    phase_d = '0;
                    state_d = RECOVER;
                end else if (phase_q >= SETUP_LAST) begin
                    en_d    = DEC_ON;
                    grant_d = idx_to_onehot(addr_q);
                    state_d = ACTIVE;
`ifdef HC138_SCHED_TIMEOUT_EN
                    hold_d  = 8'd1;
`endif
                end else begin
                    phase_d = phase_inc;
                end
            end
            ACTIVE: begin
                release_now = !bus.req[addr_q];
`ifdef HC138_SCHED_TIMEOUT_EN
                hold_d = hold_inc;
                if (!release_now && (hold_q >= HOLD_LIMIT)) begin
                    release_now = 1'b1;
                    timeout_d   = 1'b1;
                end
`endif
                if (release_now) begin
                    en_d       = DEC_OFF;
                    grant_d    = '0;
                    last_ptr_d = addr_q;
                    phase_d    = '0;
                    state_d    = RECOVER;
                end
            end
            RECOVER: begin
                if (phase_q >= RECOVER_LAST) begin
                    state_d = IDLE;
                end else begin
                    phase_d = phase_inc;
                end
            end
            default: begin
                en_d    = DEC_OFF;
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            last_ptr_q <= IDX_W'(N_REQ - 1);
            en_q       <= DEC_OFF;
            grant_q    <= '0;
            phase_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            last_ptr_q <= last_ptr_d;
            en_q       <= en_d;
            grant_q    <= grant_d;
            phase_q    <= phase_d;
        end
    end

`ifdef HC138_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.dec_addr = addr_q;
    assign bus.dec_en   = en_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_hc138_cs_scheduler.sv
// tb/tb_hc138_cs_scheduler.sv - self-checking bench for the hc138 chip-select scheduler
module tb_hc138_cs_scheduler;
    import hc138_sched_pkg::*;

    localparam int SETUP_CYC   = 1;
    localparam int RECOVER_CYC = 1;
    localparam int MAX_HOLD    = 4;
    localparam int FIRST_LAT   = 1 + SETUP_CYC;
    localparam int GAP_LAT     = RECOVER_CYC + 1 + SETUP_CYC;
    localparam int N_TV        = 16;

    typedef struct {
        logic [7:0] req;
        int         hold;
        logic [7:0] exp_grant;
    } tv_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] sb_q[$];

    hc138_cs_scheduler_if bus ();

    hc138_cs_scheduler #(
        .SETUP_CYC   (SETUP_CYC),
        .RECOVER_CYC (RECOVER_CYC),
        .MAX_HOLD    (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (bus.grant == 8'h00 && cyc < max_cyc);
        if (bus.grant == 8'h00) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_grant: got no grant after %0d cycles, expected one", cyc);
        end
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (bus.busy !== 1'b0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("wait_idle", 32'(bus.busy), 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req = 8'h00;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    // Scoreboard pop on each new grant, plus decoder-safety invariants every cycle.
    logic [7:0] prev_grant = 8'h00;
    logic [2:0] prev_en    = 3'b000;
    logic [2:0] prev_addr  = 3'b000;
    always @(negedge clk) begin
        if (bus.grant != 8'h00 && prev_grant == 8'h00) begin
            if (sb_q.size() == 0) check("sb_unexpected_grant", 32'(bus.grant), 32'h0);
            else                  check("sb_grant", 32'(bus.grant), 32'(sb_q.pop_front()));
        end
        if (bus.dec_en != DEC_OFF) begin
            check("en_level", 32'(bus.dec_en), 32'(DEC_ON));
            check("grant_is_addr", 32'(bus.grant), 32'(8'h01 << bus.dec_addr));
            if (prev_en != DEC_OFF) check("addr_stable", 32'(bus.dec_addr), 32'(prev_addr));
        end else begin
            check("grant_off", 32'(bus.grant), 32'h0);
        end
        prev_grant <= bus.grant;
        prev_en    <= bus.dec_en;
        prev_addr  <= bus.dec_addr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tv_t  tv[N_TV];
        int   cyc;
        logic ok;

        tv[0]  = '{8'hFF, 3, 8'h01};
        tv[1]  = '{8'hFF, 3, 8'h02};
        tv[2]  = '{8'hFF, 3, 8'h04};
        tv[3]  = '{8'hFF, 3, 8'h08};
        tv[4]  = '{8'hFF, 3, 8'h10};
        tv[5]  = '{8'hFF, 3, 8'h20};
        tv[6]  = '{8'hFF, 3, 8'h40};
        tv[7]  = '{8'hFF, 3, 8'h80};
        tv[8]  = '{8'hFF, 3, 8'h01};
        tv[9]  = '{8'h81, 2, 8'h80};
        tv[10] = '{8'h81, 2, 8'h01};
        tv[11] = '{8'h10, 2, 8'h10};
        tv[12] = '{8'h09, 2, 8'h01};
        tv[13] = '{8'h09, 2, 8'h08};
        tv[14] = '{8'h0C, 2, 8'h04};
        tv[15] = '{8'h24, 2, 8'h20};

        // Reset with every request raised, then first grant after release.
        bus.req = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_dec_addr", 32'(bus.dec_addr), 32'h0);
        check("rst_dec_en",   32'(bus.dec_en),   32'h0);
        check("rst_grant",    32'(bus.grant),    32'h0);
        check("rst_busy",     32'(bus.busy),     32'h0);
        check("rst_timeout",  32'(bus.timeout),  32'h0);
        @(posedge clk); #1;
        sb_q.push_back(8'h01);
        rst = 1'b0;
        wait_grant(20, cyc);
        check("rst_first_latency", 32'(cyc), 32'(FIRST_LAT));
        check("rst_first_grant", 32'(bus.grant), 32'h01);
        bus.req = 8'h00;
        @(posedge clk); #1;
        check("rel_en_off", 32'(bus.dec_en), 32'h0);
        check("rel_grant_off", 32'(bus.grant), 32'h0);
        check("rel_busy_recover", 32'(bus.busy), 32'h1);
        repeat (RECOVER_CYC) begin @(posedge clk); #1; end
        check("rel_busy_clear", 32'(bus.busy), 32'h0);

        // Single requester latency: address one edge before enable.
        @(posedge clk); #1;
        sb_q.push_back(8'h10);
        bus.req = 8'h10;
        @(posedge clk); #1;
        check("single_addr", 32'(bus.dec_addr), 32'h4);
        check("single_busy", 32'(bus.busy), 32'h1);
        check("single_en_setup", 32'(bus.dec_en), 32'h0);
        repeat (SETUP_CYC) begin @(posedge clk); #1; end
        check("single_en_on", 32'(bus.dec_en), 32'h7);
        check("single_grant", 32'(bus.grant), 32'h10);
        bus.req = 8'h00;
        @(posedge clk); #1;
        check("single_en_off", 32'(bus.dec_en), 32'h0);
        repeat (RECOVER_CYC) begin @(posedge clk); #1; end
        check("single_busy_clear", 32'(bus.busy), 32'h0);

        // Abort in SETUP leaves the round-robin pointer alone.
        do_reset();
        bus.req = 8'h20;
        @(posedge clk); #1;
        check("abort_setup_busy", 32'(bus.busy), 32'h1);
        check("abort_setup_addr", 32'(bus.dec_addr), 32'h5);
        bus.req = 8'h00;
        @(posedge clk); #1;
        check("abort_no_en", 32'(bus.dec_en), 32'h0);
        check("abort_no_grant", 32'(bus.grant), 32'h0);
        wait_idle();
        sb_q.push_back(8'h01);
        bus.req = 8'hFF;
        wait_grant(20, cyc);
        check("abort_next_grant", 32'(bus.grant), 32'h01);
        bus.req = 8'h00;
        @(posedge clk); #1;
        wait_idle();

        // Round-robin table.
        do_reset();
        for (int k = 0; k < N_TV; k++) begin
            bus.req = tv[k].req;
            sb_q.push_back(tv[k].exp_grant);
            wait_grant(40, cyc);
            check($sformatf("tv%0d_latency", k), 32'(cyc), 32'((k == 0) ? FIRST_LAT : GAP_LAT));
            check($sformatf("tv%0d_grant", k), 32'(bus.grant), 32'(tv[k].exp_grant));
            repeat (tv[k].hold - 1) begin @(posedge clk); #1; end
            check($sformatf("tv%0d_hold", k), 32'(bus.grant), 32'(tv[k].exp_grant));
            bus.req = bus.req & ~bus.grant;
            @(posedge clk); #1;
            check($sformatf("tv%0d_release", k), 32'({bus.dec_en, bus.grant}), 32'h0);
        end
        bus.req = 8'h00;
        wait_idle();

        // Hold limit behaviour.
        do_reset();
        bus.req = 8'h03;
`ifdef HC138_SCHED_TIMEOUT_EN
        sb_q.push_back(8'h01);
        sb_q.push_back(8'h02);
        wait_grant(20, cyc);
        check("to_first_grant", 32'(bus.grant), 32'h01);
        for (int c = 1; c < MAX_HOLD; c++) begin
            @(posedge clk); #1;
            check($sformatf("to_hold%0d", c), 32'({bus.timeout, bus.grant}), 32'h01);
        end
        @(posedge clk); #1;
        check("to_forced_off", 32'({bus.dec_en, bus.grant}), 32'h0);
        check("to_pulse", 32'(bus.timeout), 32'h1);
        @(posedge clk); #1;
        check("to_pulse_end", 32'(bus.timeout), 32'h0);
        wait_grant(20, cyc);
        check("to_next_gap", 32'(cyc), 32'(GAP_LAT - 1));
        check("to_next_grant", 32'(bus.grant), 32'h02);
`else
        sb_q.push_back(8'h01);
        wait_grant(20, cyc);
        check("nto_first_grant", 32'(bus.grant), 32'h01);
        ok = 1'b1;
        repeat (8 * MAX_HOLD + 8) begin
            @(posedge clk); #1;
            if (bus.grant !== 8'h01 || bus.timeout !== 1'b0) ok = 1'b0;
        end
        check("nto_hold_indefinite", 32'(ok), 32'h1);
`endif
        bus.req = 8'h00;
        @(posedge clk); #1;
        wait_idle();

        // Asynchronous reset in ACTIVE drops the decoder before the next edge.
        sb_q.push_back(8'h01);
        bus.req = 8'h01;
        wait_grant(20, cyc);
        check("arst_pre_grant", 32'(bus.grant), 32'h01);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_en", 32'(bus.dec_en), 32'h0);
        check("arst_grant", 32'(bus.grant), 32'h0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        bus.req = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
